uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
Buffered UART transmitter. It is the transmit-side counterpart to the existing uart_rx path. A small synchronous FIFO accepts bytes from the host. A baud-timed serializer emits 8N1 frames, or 8E1 frames when parity is enabled, on txd. It sits inside uart_top beside uart_rx and can drive uart_rx's rxd in loopback.

Parameters:
CLK_FREQ, 10000000, system clock frequency in Hz
BAUDRATE, 9600, line rate; bit period DIV = CLK_FREQ/BAUDRATE, integer truncation (1041 at defaults)
PARITY_EN, 0, 1 inserts an even parity bit between the data and stop bits
FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2 and at least 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe for wr_data
wr_data  in  8  byte to transmit
full  out  1  FIFO full; a write in this cycle is dropped
empty  out  1  FIFO empty
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky flag: a write was attempted while full
tx_busy  out  1  serializer is not in IDLE
txd  out  1  serial line, idles high

Behaviour:
- Reset (synchronous, dominates everything):
  - txd=1, tx_busy=0, full=0, empty=1, level=0, overflow=0.
  - FIFO is flushed, the FSM goes to IDLE, and the baud counter is cleared.
  - A frame in progress is aborted; txd is high on the cycle after rst is sampled.
- FIFO write:
  - Accepted when wr_en && !full.
  - wr_en && full drops the byte and sets overflow. overflow clears only on rst.
  - full is judged on the registered state. A pop in the same cycle does not make room for that cycle's write.
- FIFO pop: performed only by the FSM. A write and a pop in the same cycle leave level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. If !empty, pop into the shift register and go to START next cycle.
  - START: txd=0 for DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each held DIV cycles. A 3-bit index counts 0..7. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: txd = XOR of the 8 data bits (even parity), held DIV cycles, then STOP.
  - STOP: txd=1 for DIV cycles. At the end, if !empty, pop and go directly to START (back-to-back, no gap); else go to IDLE.
- Baud counter: counts 0..DIV-1 and restarts on every state entry, so every bit lasts exactly DIV cycles.
- Latency: wr_en at cycle 0 into an empty, idle block gives empty=0 at cycle 1, the pop at cycle 1, and txd=0 from cycle 2.
- tx_busy: high from the START entry until the cycle the FSM returns to IDLE.
- Frame length: 10*DIV cycles, or 11*DIV with parity.
- txd is driven from a register (glitch-free).
- FIFO pointers wrap modulo FIFO_DEPTH. level is the difference of pointers that carry one extra bit.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port brk (1 bit).
  - While brk=1 and the FSM is in IDLE, txd=0 and no pop occurs.
  - brk is ignored mid-frame and takes effect at the next IDLE.
  - When brk deasserts, txd returns to 1 the next cycle.
  - tx_busy stays 0 during a break.
- Undefined: no brk port; behaviour is exactly as described above.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding constants;
  - DATA_BITS=8;
  - an even-parity function.
  These are shared with uart_rx.
- Sub-module uart_sync_fifo is a parameterised width/depth synchronous FIFO providing full, empty and level.
- The serializer FSM and baud counter stay in uart_tx_buf.

Test Plan:
1. Defaults, write 0x5C at cycle 0 -> txd falls at cycle 2; bits 0,0,1,1,1,0,1,0 follow, each 1041 cycles; stop high; tx_busy falls 10410 cycles after the start edge.
2. Write 0x5C then 0xDE on consecutive cycles -> the second start bit begins exactly when the first stop bit ends; empty=1 after the second pop.
3. wr_en on 6 consecutive cycles (A..F) -> A popped at cycle 1; B..E accepted; full=1 and level=4 at cycle 5; F dropped; overflow=1 and sticky.
4. PARITY_EN=1, send 0xDE then 0x5B -> parity bits 0 and 1 respectively; each frame is 11*1041 cycles.
5. Assert rst during DATA bit 3 of 0xDE with 2 bytes queued -> txd=1 next cycle; level=0, tx_busy=0; nothing transmitted afterwards.
6. Loopback in uart_top to uart_rx, send 0x5C and 0xDE -> rx_dfifo matches each byte; rx_parity_err stays 0 with PARITY_EN=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
//   DATA_BITS    : payload bits per frame
//   uart_state_e : serializer/deserializer state encoding
//   even_parity  : XOR of the payload bits (1 when the count of ones is odd)
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; status is derived from registered pointers.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data       : push request (ignored while full)
//   rd_en                : pop request (ignored while empty)
//   rd_data_c            : head entry, valid while !empty_c
//   full_c, empty_c      : occupancy flags
//   level_c              : occupancy count, 0..DEPTH
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     level_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Status from pointers; a same-cycle pop never frees space for this cycle's push.
  always_comb begin
    level_c   = wr_ptr_q - rd_ptr_q;
    full_c    = (level_c == PW'(DEPTH));
    empty_c   = (wr_ptr_q == rd_ptr_q);
    do_wr     = wr_en & ~full_c;
    do_rd     = rd_en & ~empty_c;
    wr_ptr_d  = wr_ptr_q + PW'(do_wr);
    rd_ptr_d  = rd_ptr_q + PW'(do_rd);
    rd_data_c = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO in front of a baud-timed 8N1 / 8E1 serializer.
// Optional feature macro: UART_TX_BREAK_EN adds input brk (line held low while idle).
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    : host byte write (dropped while full)
//   full, empty, level: FIFO status
//   overflow          : sticky, set by a write attempted while full
//   tx_busy           : serializer is transmitting a frame
//   txd               : registered serial line, idles high
//   brk               : (UART_TX_BREAK_EN only) break request
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 10000000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          txd
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                          brk
`endif
);

  localparam int unsigned DIV   = CLK_FREQ / BAUDRATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   txd_q, txd_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   overflow_q, overflow_d;
  logic                   pop_c;
  logic                   bit_end_c;
  logic                   brk_c;
  logic [DATA_BITS-1:0]   fifo_data_c;

`ifdef UART_TX_BREAK_EN
  assign brk_c = brk;
`else
  assign brk_c = 1'b0;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (pop_c),
    .rd_data_c (fifo_data_c),
    .full_c    (full),
    .empty_c   (empty),
    .level_c   (level)
  );

  // Next-state, baud timing and line value; txd is computed from the next state so it is registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    pop_c      = 1'b0;
    overflow_d = overflow_q | (wr_en & full);
    bit_end_c  = (cnt_q == CNT_W'(DIV - 1));

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty && !brk_c) begin
          pop_c   = 1'b1;
          data_d  = fifo_data_c;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          cnt_d = '0;
          // Back-to-back: the next start bit follows the stop bit with no idle gap.
          if (!empty) begin
            pop_c   = 1'b1;
            data_d  = fifo_data_c;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE:   txd_d = ~brk_c;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = data_d[bit_idx_d];
      ST_PARITY: txd_d = even_parity(data_d);
      default:   txd_d = 1'b1;
    endcase

    tx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      txd_q      <= txd_d;
      tx_busy_q  <= tx_busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign txd      = txd_q;
  assign tx_busy  = tx_busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: instance A at default rates (no parity), instance B fast with parity.
module tb_uart_tx_buf;

  localparam int unsigned DIV_A  = 10000000 / 9600;
  localparam int unsigned CLK_B  = 1000000;
  localparam int unsigned BAUD_B = 96000;
  localparam int unsigned DIV_B  = CLK_B / BAUD_B;

  logic       clk;
  logic       rst_a, wr_en_a, full_a, empty_a, overflow_a, tx_busy_a, txd_a;
  logic [7:0] wr_data_a;
  logic [2:0] level_a;
  logic       rst_b, wr_en_b, full_b, empty_b, overflow_b, tx_busy_b, txd_b;
  logic [7:0] wr_data_b;
  logic [2:0] level_b;
`ifdef UART_TX_BREAK_EN
  logic       brk_a, brk_b;
`endif

  int checks = 0;
  int passed = 0;

  uart_tx_buf dut_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .empty(empty_a), .level(level_a), .overflow(overflow_a),
    .tx_busy(tx_busy_a), .txd(txd_a)
`ifdef UART_TX_BREAK_EN
    , .brk(brk_a)
`endif
  );

  uart_tx_buf #(.CLK_FREQ(CLK_B), .BAUDRATE(BAUD_B), .PARITY_EN(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .empty(empty_b), .level(level_b), .overflow(overflow_b),
    .tx_busy(tx_busy_b), .txd(txd_b)
`ifdef UART_TX_BREAK_EN
    , .brk(brk_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference line: per byte start(0), 8 data LSB first, optional even parity, stop(1); idle 1 after.
  function automatic logic [63:0] model_line(input logic [7:0] bytes [$], input bit par);
    logic [63:0] r;
    int n;
    int ones;
    r = '1;
    n = 0;
    foreach (bytes[i]) begin
      r[n] = 1'b0; n++;
      ones = 0;
      for (int k = 0; k < 8; k++) begin
        r[n] = bytes[i][k];
        if (bytes[i][k]) ones++;
        n++;
      end
      if (par) begin
        r[n] = ((ones % 2) == 1); n++;
      end
      r[n] = 1'b1; n++;
    end
    return r;
  endfunction

  // Samples nbits bit periods starting at the current cycle; a bit not constant over its period reads as x.
  task automatic capture(input bit sel_b, input int div, input int nbits,
                         output logic [63:0] val, output bit busy_all);
    logic v;
    logic s;
    val = '1;
    busy_all = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      v = sel_b ? txd_b : txd_a;
      for (int c = 0; c < div; c++) begin
        s = sel_b ? txd_b : txd_a;
        if (s !== v) v = 1'bx;
        if ((sel_b ? tx_busy_b : tx_busy_a) !== 1'b1) busy_all = 1'b0;
        @(negedge clk);
      end
      val[b] = v;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; wr_en_a = 1'b1; wr_en_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
    checks++; if ({txd_a, tx_busy_a, full_a, empty_a, level_a, overflow_a} !== 8'b1001_0000)
      $display("FAIL reset_a: got %b want 10010000", {txd_a, tx_busy_a, full_a, empty_a, level_a, overflow_a});
    else passed++;
    checks++; if ({txd_b, tx_busy_b, full_b, empty_b, level_b, overflow_b} !== 8'b1001_0000)
      $display("FAIL reset_b: got %b want 10010000", {txd_b, tx_busy_b, full_b, empty_b, level_b, overflow_b});
    else passed++;
  endtask

  task automatic test_single;
    logic [7:0] q [$];
    logic [63:0] val, exp;
    bit busy;
    q = {8'h5C};
    exp = model_line(q, 1'b0);
    wr_en_a = 1'b1; wr_data_a = 8'h5C;
    @(negedge clk);
    wr_en_a = 1'b0;
    checks++; if ({empty_a, txd_a, tx_busy_a} !== 3'b010)
      $display("FAIL single_cyc1: empty/txd/busy got %b want 010", {empty_a, txd_a, tx_busy_a});
    else passed++;
    @(negedge clk);
    capture(1'b0, DIV_A, 10, val, busy);
    checks++; if (val !== exp) $display("FAIL single_frame: got %h want %h", val, exp); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
    checks++; if ({tx_busy_a, txd_a, empty_a} !== 3'b011)
      $display("FAIL single_end: busy/txd/empty got %b want 011", {tx_busy_a, txd_a, empty_a});
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [63:0] val;
    bit busy;
    q1 = {8'h5C};
    q2 = {8'hDE};
    wr_en_a = 1'b1; wr_data_a = 8'h5C;
    @(negedge clk);
    wr_data_a = 8'hDE;
    @(negedge clk);
    wr_en_a = 1'b0;
    checks++; if ({level_a, txd_a} !== 4'b0010)
      $display("FAIL b2b_cyc2: level/txd got %b want 0010", {level_a, txd_a});
    else passed++;
    capture(1'b0, DIV_A, 10, val, busy);
    checks++; if (val !== model_line(q1, 1'b0)) $display("FAIL b2b_frame1: got %h want %h", val, model_line(q1, 1'b0)); else passed++;
    checks++; if ({empty_a, tx_busy_a, txd_a} !== 3'b110)
      $display("FAIL b2b_gap: empty/busy/txd got %b want 110", {empty_a, tx_busy_a, txd_a});
    else passed++;
    capture(1'b0, DIV_A, 10, val, busy);
    checks++; if (val !== model_line(q2, 1'b0)) $display("FAIL b2b_frame2: got %h want %h", val, model_line(q2, 1'b0)); else passed++;
    checks++; if ({busy, tx_busy_a, txd_a} !== 3'b101)
      $display("FAIL b2b_end: busy_all/busy/txd got %b want 101", {busy, tx_busy_a, txd_a});
    else passed++;
  endtask

  // Overflow with A..F, then a reset in the middle of data bit 3 of the first frame.
  task automatic test_overflow_abort;
    logic [7:0] bytes [6];
    logic [2:0] exp_lvl [6];
    int lows, busys;
    exp_lvl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    bytes[0] = 8'hDE;
    for (int i = 1; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      checks++; if ({full_a, level_a} !== {(i == 5), exp_lvl[i]})
        $display("FAIL ovf_level_c%0d: full/level got %b/%0d want %b/%0d", i, full_a, level_a, (i == 5), exp_lvl[i]);
      else passed++;
      if (i == 5) begin
        checks++; if (overflow_a !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow_a); else passed++;
      end
      wr_en_a = 1'b1; wr_data_a = bytes[i];
      @(negedge clk);
    end
    wr_en_a = 1'b0;
    checks++; if ({overflow_a, full_a, level_a} !== 5'b11100)
      $display("FAIL ovf_set: ovf/full/level got %b want 11100", {overflow_a, full_a, level_a});
    else passed++;
    repeat (4 * DIV_A + DIV_A / 2 - 4) @(negedge clk);
    checks++; if ({overflow_a, tx_busy_a, level_a, txd_a} !== {2'b11, 3'd4, bytes[0][3]})
      $display("FAIL abort_pre: ovf/busy/level/txd got %b want %b", {overflow_a, tx_busy_a, level_a, txd_a}, {2'b11, 3'd4, bytes[0][3]});
    else passed++;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    checks++; if ({txd_a, tx_busy_a, level_a, empty_a, full_a, overflow_a} !== 8'b1000_0100)
      $display("FAIL abort_post: got %b want 10000100", {txd_a, tx_busy_a, level_a, empty_a, full_a, overflow_a});
    else passed++;
    lows = 0; busys = 0;
    repeat (11 * DIV_A) begin
      if (txd_a !== 1'b1) lows++;
      if (tx_busy_a !== 1'b0) busys++;
      @(negedge clk);
    end
    checks++; if (lows + busys != 0)
      $display("FAIL abort_quiet: txd-low cycles %0d busy cycles %0d want 0/0", lows, busys);
    else passed++;
  endtask

  task automatic test_parity;
    logic [7:0] q [$];
    logic [63:0] val, exp;
    bit busy;
    q = {8'hDE, 8'h5B};
    exp = model_line(q, 1'b1);
    wr_en_b = 1'b1; wr_data_b = 8'hDE;
    @(negedge clk);
    wr_data_b = 8'h5B;
    @(negedge clk);
    wr_en_b = 1'b0;
    capture(1'b1, DIV_B, 22, val, busy);
    checks++; if (val !== exp) $display("FAIL parity_frames: got %h want %h", val, exp); else passed++;
    checks++; if ({val[9], val[20]} !== 2'b01)
      $display("FAIL parity_bits: got %b want 01", {val[9], val[20]});
    else passed++;
    checks++; if ({busy, tx_busy_b, txd_b} !== 3'b101)
      $display("FAIL parity_end: busy_all/busy/txd got %b want 101", {busy, tx_busy_b, txd_b});
    else passed++;
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic [63:0] val, exp;
    bit busy;
    int n, gap;
    for (int it = 0; it < 8; it++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
      checks++; if ({txd_b, tx_busy_b, empty_b} !== 3'b101)
        $display("FAIL rand_idle_%0d: txd/busy/empty got %b want 101", it, {txd_b, tx_busy_b, empty_b});
      else passed++;
      n = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      exp = model_line(q, 1'b1);
      fork
        begin
          for (int i = 0; i < n; i++) begin
            wr_en_b = 1'b1; wr_data_b = q[i];
            @(negedge clk);
          end
          wr_en_b = 1'b0;
        end
        begin
          repeat (2) @(negedge clk);
          capture(1'b1, DIV_B, 11 * n, val, busy);
        end
      join
      checks++; if (val !== exp) $display("FAIL rand_frames_%0d (n=%0d): got %h want %h", it, n, val, exp); else passed++;
      checks++; if ({busy, tx_busy_b, overflow_b} !== 3'b100)
        $display("FAIL rand_end_%0d: busy_all/busy/ovf got %b want 100", it, {busy, tx_busy_b, overflow_b});
      else passed++;
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    logic [7:0] q [$];
    logic [63:0] val;
    bit busy;
    q = {8'($urandom)};
    brk_b = 1'b1;
    @(negedge clk);
    checks++; if ({txd_b, tx_busy_b} !== 2'b00) $display("FAIL brk_on: txd/busy got %b want 00", {txd_b, tx_busy_b}); else passed++;
    brk_b = 1'b0;
    @(negedge clk);
    checks++; if (txd_b !== 1'b1) $display("FAIL brk_off: txd got %b want 1", txd_b); else passed++;
    brk_b = 1'b1;
    wr_en_b = 1'b1; wr_data_b = q[0];
    @(negedge clk);
    wr_en_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({level_b, txd_b, tx_busy_b} !== 5'b00100)
      $display("FAIL brk_hold: level/txd/busy got %b want 00100", {level_b, txd_b, tx_busy_b});
    else passed++;
    brk_b = 1'b0;
    @(negedge clk);
    capture(1'b1, DIV_B, 11, val, busy);
    checks++; if (val !== model_line(q, 1'b1)) $display("FAIL brk_frame: got %h want %h", val, model_line(q, 1'b1)); else passed++;
  endtask
`endif

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    wr_en_a = 1'b0; wr_en_b = 1'b0;
    wr_data_a = 8'h00; wr_data_b = 8'h00;
`ifdef UART_TX_BREAK_EN
    brk_a = 1'b0; brk_b = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow_abort();
    test_parity();
    test_random();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
